// File: rtl/display_arbiter_pkg.sv
// Shared types and helpers for the display arbiter: FSM encoding, digit geometry
// and the one-hot grant encoder.
package display_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHOW  = 2'd1,
    BLANK = 2'd2
  } state_t;

  localparam int DIGIT_W = 4;
  localparam int DIGITS  = 4;
  localparam int WORD_W  = DIGIT_W * DIGITS;
  localparam int MAX_REQ = 8;
  localparam int MAX_IDX_W = 3;

  // Callers size-cast the result down to their own requester count.
  function automatic logic [MAX_REQ-1:0] onehot(input logic [MAX_IDX_W-1:0] idx);
    return MAX_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/display_arbiter_if.sv
// Requester-side bundle of the display arbiter: enable, requests, digit words,
// and the grant/valid/digit outputs toward the seven-segment scan driver.
interface display_arbiter_if #(
  parameter int N_REQ = 3
);
  import display_pkg::*;

  logic                      enable;
  logic [N_REQ-1:0]          req;
  logic [WORD_W*N_REQ-1:0]   data;
  logic [N_REQ-1:0]          grant;
  logic                      valid;
  logic [DIGIT_W-1:0]        d0;
  logic [DIGIT_W-1:0]        d1;
  logic [DIGIT_W-1:0]        d2;
  logic [DIGIT_W-1:0]        d3;

  modport master (
    output enable, req, data,
    input  grant, valid, d0, d1, d2, d3
  );

  modport slave (
    input  enable, req, data,
    output grant, valid, d0, d1, d2, d3
  );

endinterface

// File: rtl/display_arbiter_rr_pick.sv
// Combinational winner selection: optional fixed priority for requester 0,
// otherwise round-robin starting just above the last winner.
module rr_pick #(
  parameter int N_REQ   = 3,
  parameter bit PRIO_EN = 1'b1,
  parameter int IDX_W   = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [IDX_W-1:0] winner,
  output logic             any
);

  assign any = |req;

  always_comb begin
    logic             found;
    logic [IDX_W-1:0] idx;
    // NOTE: every variable gets a default before any branch so no path leaves it unassigned (no latch).
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    if (PRIO_EN && req[0]) begin
      found = 1'b1;
    end
    // Offsets 1..N_REQ wrap back to rr_ptr itself last, so a lone previous owner still wins.
    for (int k = 1; k <= N_REQ; k++) begin
      idx = IDX_W'((int'(rr_ptr) + k) % N_REQ);
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/display_arbiter.sv
// Shares the 4-digit seven-segment display among N_REQ requesters with minimum hold,
// round-robin rotation, requester-0 pre-emption and a blank gap between owners.
module display_arbiter
  import display_pkg::*;
#(
  parameter int N_REQ      = 3,
  parameter int TICK_DIV   = 4,
  parameter int HOLD_TICKS = 2,
  parameter bit PRIO_EN    = 1'b1
) (
  input logic              clk,
  input logic              rst,
  display_arbiter_if.slave bus
);

  localparam int IDX_W  = $clog2(N_REQ);
  localparam int PRE_W  = $clog2(TICK_DIV);
  localparam int HOLD_W = $clog2(HOLD_TICKS + 1);

  state_t             state;
  logic [PRE_W-1:0]   presc;
  logic [IDX_W-1:0]   rr_ptr;
  logic [HOLD_W-1:0]  hold_cnt;
  logic [N_REQ-1:0]   grant_q;
  logic               valid_q;
  logic [WORD_W-1:0]  disp_q;

  logic [WORD_W-1:0]  words [N_REQ];
  logic [IDX_W-1:0]   winner;
  logic               any;
  logic               tick;
  logic               others;
  logic               owner_req;
  logic               preempt;
  logic               launch;

  for (genvar i = 0; i < N_REQ; i++) begin : g_words
    assign words[i] = bus.data[WORD_W*i +: WORD_W];
  end

  rr_pick #(.N_REQ(N_REQ), .PRIO_EN(PRIO_EN), .IDX_W(IDX_W)) u_pick (
    .req    (bus.req),
    .rr_ptr (rr_ptr),
    .winner (winner),
    .any    (any)
  );

  // While showing, rr_ptr always holds the current owner's index.
  assign tick      = (presc == PRE_W'(TICK_DIV - 1));
  assign others    = |(bus.req & ~grant_q);
  assign owner_req = bus.req[rr_ptr];
  assign preempt   = PRIO_EN && (rr_ptr != '0) && bus.req[0];
  assign launch    = any && ((state == IDLE) || (state == BLANK && tick));

  always_ff @(posedge clk) begin
    // NOTE: all state uses non-blocking assignment so every register samples pre-edge values.
    if (rst) begin
      state    <= IDLE;
      presc    <= '0;
      rr_ptr   <= IDX_W'(N_REQ - 1);
      hold_cnt <= '0;
      grant_q  <= '0;
      valid_q  <= 1'b0;
      disp_q   <= '0;
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      if (!bus.enable) begin
        state    <= IDLE;
        hold_cnt <= '0;
        grant_q  <= '0;
        valid_q  <= 1'b0;
        disp_q   <= '0;
      end else if (launch) begin
        state    <= SHOW;
        grant_q  <= N_REQ'(onehot(MAX_IDX_W'(winner)));
        valid_q  <= 1'b1;
        disp_q   <= words[winner];
        hold_cnt <= HOLD_W'(HOLD_TICKS);
        rr_ptr   <= winner;
      end else begin
        case (state)
          SHOW: begin
            disp_q <= words[rr_ptr];
            if (preempt || !owner_req) begin
              state   <= (preempt || others) ? BLANK : IDLE;
              grant_q <= '0;
              valid_q <= 1'b0;
            end else if (tick) begin
              if (hold_cnt == HOLD_W'(1)) begin
                if (others) begin
                  state   <= BLANK;
                  grant_q <= '0;
                  valid_q <= 1'b0;
                end else begin
                  hold_cnt <= HOLD_W'(HOLD_TICKS);
                end
              end else begin
                hold_cnt <= hold_cnt - 1'b1;
              end
            end
          end
          BLANK: begin
            if (tick) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.grant = grant_q;
  assign bus.valid = valid_q;
  assign bus.d0    = disp_q[3:0];
  assign bus.d1    = disp_q[7:4];
  assign bus.d2    = disp_q[11:8];
  assign bus.d3    = disp_q[15:12];

endmodule
